// File: rtl/ft245r_fifo_if.sv
// ft245r_fifo_if: FT245R receive reader feeding a first-word-fall-through byte FIFO.
// Ports: clk, rst (sync, active-high); usb_bus/usb_rxf_/usb_txe_/usb_rd_/usb_wr
// to the chip; usbval/usb_pop/usb_empty/usb_full to the modulator control logic.
module ft245r_fifo_if #(
  parameter int RD_CYCLES  = 3,
  parameter int REC_CYCLES = 5,
  parameter int DEPTH      = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] usb_bus,
  input  logic       usb_rxf_,
  input  logic       usb_txe_,
  output logic       usb_rd_,
  output logic       usb_wr,
  output logic [7:0] usbval,
  input  logic       usb_pop,
  output logic       usb_empty,
  output logic       usb_full
);

  localparam int PW   = $clog2(DEPTH);
  localparam int NW   = PW + 1;
  localparam int MAXC = (RD_CYCLES > REC_CYCLES) ? RD_CYCLES : REC_CYCLES;
  localparam int CW   = $clog2(MAXC) + 1;

  localparam logic [CW-1:0] RD_LAST  = CW'(RD_CYCLES - 1);
  localparam logic [CW-1:0] REC_LAST = CW'(REC_CYCLES - 1);
  localparam logic [NW-1:0] FULL_N   = NW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    RD_LOW,
    RECOVER
  } state_t;

  state_t        state;
  logic [CW-1:0] cyc;
  logic          rxf_q;
  logic          rxf_s;
  logic          push;
  logic          pop;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [NW-1:0] count;
  logic [7:0]    mem [DEPTH];

  // Transmit side is not used.
  logic unused_txe;
  assign unused_txe = usb_txe_;
  assign usb_wr     = 1'b0;

  // RXF# is asynchronous to clk.
  always_ff @(posedge clk) begin
    if (rst) begin
      rxf_q <= 1'b1;
      rxf_s <= 1'b1;
    end else begin
      rxf_q <= usb_rxf_;
      rxf_s <= rxf_q;
    end
  end

  // Bus is captured on the same edge that ends the RD# low phase.
  assign push = (state == RD_LOW) && (cyc == RD_LAST);
  assign pop  = usb_pop && !usb_empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      usb_rd_ <= 1'b1;
      cyc     <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (!rxf_s && !usb_full) begin
            state   <= RD_LOW;
            usb_rd_ <= 1'b0;
            cyc     <= '0;
          end
        end
        RD_LOW: begin
          if (cyc == RD_LAST) begin
            state   <= RECOVER;
            usb_rd_ <= 1'b1;
            cyc     <= '0;
          end else begin
            cyc <= cyc + CW'(1);
          end
        end
        RECOVER: begin
          if (cyc == REC_LAST) begin
            state <= IDLE;
          end else begin
            cyc <= cyc + CW'(1);
          end
        end
        default: begin
          state   <= IDLE;
          usb_rd_ <= 1'b1;
          cyc     <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push && !rst) begin
      mem[wr_ptr] <= usb_bus;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      if (push && !pop) begin
        count <= count + NW'(1);
      end else if (pop && !push) begin
        count <= count - NW'(1);
      end
    end
  end

  assign usb_empty = (count == '0);
  assign usb_full  = (count == FULL_N);
  assign usbval    = usb_empty ? 8'h00 : mem[rd_ptr];

endmodule

// File: tb/tb_ft245r_fifo_if.sv
// tb_ft245r_fifo_if: random FT245R chip model plus byte-order scoreboard.
// Checks RD# timing, flow control, FWFT head/flags and reset behaviour.
module tb_ft245r_fifo_if;

  localparam int RDC   = 3;
  localparam int RECC  = 5;
  localparam int DEPTH = 16;
  localparam int SPACE = RDC + RECC + 1;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] usb_bus;
  logic       usb_rxf_;
  logic       usb_txe_ = 1'b1;
  logic       usb_rd_;
  logic       usb_wr;
  logic [7:0] usbval;
  logic       usb_pop;
  logic       usb_empty;
  logic       usb_full;

  ft245r_fifo_if #(
    .RD_CYCLES (RDC),
    .REC_CYCLES(RECC),
    .DEPTH     (DEPTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .usb_bus  (usb_bus),
    .usb_rxf_ (usb_rxf_),
    .usb_txe_ (usb_txe_),
    .usb_rd_  (usb_rd_),
    .usb_wr   (usb_wr),
    .usbval   (usbval),
    .usb_pop  (usb_pop),
    .usb_empty(usb_empty),
    .usb_full (usb_full)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] src_q [$];
  logic [7:0] exp_q [$];
  int         falls_q [$];

  int cyc       = 0;
  int last_fall = -1000;
  int fall_cnt  = 0;
  int low_len   = 0;
  int gap       = 0;
  int gap_max   = 0;
  bit stale     = 1'b0;
  bit prev_rd   = 1'b1;
  bit pop_e     = 1'b0;
  bit rst_e     = 1'b1;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", tag, got, want);
    end
  endtask

  // Inputs seen by the DUT at each rising edge.
  initial forever begin
    @(posedge clk);
    pop_e = usb_pop;
    rst_e = rst;
  end

  // Chip model and scoreboard, evaluated between edges.
  initial begin
    bit rose;
    bit fell;
    usb_rxf_ = 1'b1;
    usb_bus  = 8'h00;
    forever begin
      @(negedge clk);
      cyc++;
      rose = !prev_rd && usb_rd_;
      fell = prev_rd && !usb_rd_;
      if (rst_e) begin
        exp_q.delete();
        chk("rst_rd", usb_rd_, 1);
        last_fall = -1000;
      end else begin
        if (fell) begin
          chk("flow_full", exp_q.size() < DEPTH, 1);
          chk("rd_no_data", src_q.size() > 0, 1);
          chk("rd_space", (cyc - last_fall) >= SPACE, 1);
          last_fall = cyc;
          fall_cnt++;
          falls_q.push_back(cyc);
        end
        if (rose) begin
          chk("rd_width", low_len, RDC);
        end
        if (pop_e && exp_q.size() > 0) begin
          void'(exp_q.pop_front());
        end
        if (rose && src_q.size() > 0) begin
          exp_q.push_back(src_q[0]);
        end
      end
      // A read consumes the byte even if the reader then discards it.
      if (rose) begin
        if (src_q.size() > 0) void'(src_q.pop_front());
        stale = 1'b1;
      end else if (stale) begin
        stale = 1'b0;
        gap   = 1 + $urandom_range(gap_max, 0);
      end else if (gap > 0) begin
        gap--;
      end
      usb_rxf_ = !(stale || (gap == 0 && src_q.size() > 0));
      usb_bus  = (src_q.size() > 0) ? src_q[0] : 8'h00;
      chk("empty", usb_empty, exp_q.size() == 0);
      chk("full", usb_full, exp_q.size() == DEPTH);
      chk("usbval", usbval, (exp_q.size() > 0) ? exp_q[0] : 8'h00);
      chk("wr", usb_wr, 0);
      low_len = (usb_rd_ || rst_e) ? 0 : low_len + 1;
      prev_rd = usb_rd_;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1);
  end

  task automatic wait_nonempty(input string tag, input int bound);
    int n = 0;
    while (usb_empty && n < bound) begin
      @(negedge clk);
      n++;
    end
    chk(tag, n < bound, 1);
  endtask

  task automatic wait_rd_low(input string tag, input int bound);
    int n = 0;
    while (usb_rd_ && n < bound) begin
      @(negedge clk);
      n++;
    end
    chk(tag, n < bound, 1);
  endtask

  task automatic wait_full(input string tag, input int bound);
    int n = 0;
    while (!usb_full && n < bound) begin
      @(negedge clk);
      n++;
    end
    chk(tag, n < bound, 1);
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((!usb_empty || src_q.size() > 0 || !usb_rd_) && n < 800) begin
      usb_pop = 1'b1;
      @(negedge clk);
      n++;
    end
    usb_pop = 1'b0;
    chk(tag, n < 800, 1);
  endtask

  initial begin
    int fc;
    int idx;
    int n;
    rst     = 1'b1;
    usb_pop = 1'b0;
    src_q.push_back(8'hA5);

    // Reset with RXF# already low.
    @(negedge clk);
    chk("rst_rd_in", usb_rd_, 1);
    chk("rst_empty", usb_empty, 1);
    chk("rst_val", usbval, 8'h00);
    chk("rst_wr", usb_wr, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_rd", usb_rd_, 1);
    chk("post_rst_empty", usb_empty, 1);
    chk("post_rst_val", usbval, 8'h00);

    // Single byte timing.
    @(negedge clk);
    chk("rd_edge2", usb_rd_, 1);
    @(negedge clk);
    chk("rd_edge3", usb_rd_, 0);
    repeat (2) @(negedge clk);
    chk("rd_edge5", usb_rd_, 0);
    chk("empty_edge5", usb_empty, 1);
    @(negedge clk);
    chk("rd_edge6", usb_rd_, 1);
    chk("val_edge6", usbval, 8'hA5);
    chk("empty_edge6", usb_empty, 0);
    fc = fall_cnt;
    repeat (20) @(negedge clk);
    chk("single_no_2nd", fall_cnt - fc, 0);
    usb_pop = 1'b1;
    @(negedge clk);
    usb_pop = 1'b0;
    chk("single_popped", usb_empty, 1);
    chk("single_val0", usbval, 8'h00);

    // Back-to-back burst.
    idx = falls_q.size();
    for (int i = 1; i <= 5; i++) src_q.push_back(8'(i));
    n = 0;
    while (exp_q.size() < 5 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("burst_to", n < 200, 1);
    for (int i = 1; i <= 4; i++) begin
      if (falls_q.size() > idx + i)
        chk("burst_space", falls_q[idx+i] - falls_q[idx+i-1], SPACE);
    end
    usb_pop = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      chk("burst_head", usbval, i);
      @(negedge clk);
    end
    usb_pop = 1'b0;
    chk("burst_empty", usb_empty, 1);
    chk("burst_val0", usbval, 8'h00);

    // Fill to full with random data and gaps.
    gap_max = 3;
    repeat (20) src_q.push_back(8'($urandom));
    wait_full("full_to", 900);
    chk("full_set", usb_full, 1);
    fc = fall_cnt;
    repeat (30) @(negedge clk);
    chk("full_no_rd", fall_cnt - fc, 0);
    chk("full_rd_hi", usb_rd_, 1);
    usb_pop = 1'b1;
    @(negedge clk);
    usb_pop = 1'b0;
    chk("full_dropped", usb_full, 0);
    wait_full("refull_to", 80);
    repeat (20) @(negedge clk);
    chk("full_one_more", fall_cnt - fc, 1);
    chk("full_again", usb_full, 1);
    drain("full_drain");

    // Push and pop on the same edge, across the pointer wrap.
    gap_max = 0;
    src_q.push_back(8'($urandom));
    wait_nonempty("pp_pre", 100);
    repeat (20) src_q.push_back(8'($urandom));
    for (int i = 0; i < 20; i++) begin
      wait_rd_low("pp_rd", 100);
      repeat (2) @(negedge clk);
      usb_pop = 1'b1;
      @(negedge clk);
      usb_pop = 1'b0;
      chk("pp_occ1", usb_empty, 0);
      chk("pp_notfull", usb_full, 0);
    end
    drain("pp_drain");

    // Reset in the middle of a read.
    repeat (3) src_q.push_back(8'($urandom));
    wait_nonempty("mr_first", 100);
    wait_rd_low("mr_rd", 100);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mr_rd_hi", usb_rd_, 1);
    chk("mr_empty", usb_empty, 1);
    chk("mr_val0", usbval, 8'h00);
    fc = fall_cnt;
    drain("mr_drain");
    chk("mr_resume", fall_cnt - fc, 1);

    // Random pops against random arrivals.
    gap_max = 4;
    repeat (30) src_q.push_back(8'($urandom));
    n = 0;
    while ((src_q.size() > 0 || !usb_empty) && n < 2000) begin
      usb_pop = ($urandom_range(2, 0) == 0);
      @(negedge clk);
      n++;
    end
    usb_pop = 1'b0;
    chk("rand_to", n < 2000, 1);

    // Pops while empty are ignored.
    usb_pop = 1'b1;
    repeat (2) @(negedge clk);
    usb_pop = 1'b0;
    chk("pop_empty", usb_empty, 1);
    chk("pop_empty_full", usb_full, 0);
    chk("pop_empty_val", usbval, 8'h00);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
